// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited word fetches feeding a 2-entry {instr, pc, fault} buffer.
// Optional misaligned-redirect fault entries are enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        instr_fault_o
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0] fetchPc_q, fetchPc_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  discard_q, discard_d;
    logic        holdReq_q, holdReq_d;
    logic [31:0] holdAddr_q, holdAddr_d;
    logic        faultPending_q, faultPending_d;
    logic        stalled_q, stalled_d;
    logic [31:0] bufInstr_q [2];
    logic [31:0] bufInstr_d [2];
    logic [31:0] bufPc_q [2];
    logic [31:0] bufPc_d [2];
    logic        bufFault_q [2];
    logic        bufFault_d [2];
    logic [31:0] inflightPc_q [2];
    logic [31:0] inflightPc_d [2];

    logic [31:0] redirectTarget;
    logic        redirectMisaligned;
    logic        normalReq, grant, holdGrant, normalGrant;
    logic        respValid, respDrop, faultPush, pushEn, popEn;
    logic [31:0] pushInstr, pushPc;
    logic        pushFault;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirectTarget     = redirect_pc_i;
    assign redirectMisaligned = (redirect_pc_i[1:0] != 2'b00);
    assign instr_fault_o      = bufFault_q[0];
`else
    logic unusedBits;
    assign redirectTarget     = {redirect_pc_i[31:2], 2'b00};
    assign redirectMisaligned = 1'b0;
    assign instr_fault_o      = 1'b0;
    assign unusedBits         = ^{redirect_pc_i[1:0], bufFault_q[0]};
`endif

    // A request held across a redirect keeps its old address until granted; its data is discarded.
    assign normalReq   = !holdReq_q && !stalled_q && (discard_q == 2'd0) &&
                         (({1'b0, count_q} + {1'b0, outstanding_q}) < 3'd2);
    assign mem_req_o   = !reset_i && (holdReq_q || normalReq);
    assign mem_addr_o  = holdReq_q ? holdAddr_q : fetchPc_q;
    assign grant       = mem_req_o && mem_gnt_i;
    assign holdGrant   = grant && holdReq_q;
    assign normalGrant = grant && !holdReq_q;

    assign respValid = mem_rvalid_i && (outstanding_q != 2'd0);
    assign respDrop  = respValid && (discard_q != 2'd0);
    assign faultPush = faultPending_q && (discard_q == 2'd0) && !holdReq_q && (outstanding_q == 2'd0);
    assign pushEn    = !redirect_i && ((respValid && !respDrop) || faultPush);
    assign popEn     = !redirect_i && instr_valid_o && instr_ready_i;
    assign pushInstr = faultPush ? NOP_INSTR : mem_rdata_i;
    assign pushPc    = faultPush ? fetchPc_q : inflightPc_q[0];
    assign pushFault = faultPush;

    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = bufInstr_q[0];
    assign instr_pc_o    = bufPc_q[0];

    always_comb begin
        fetchPc_d      = fetchPc_q;
        count_d        = count_q;
        outstanding_d  = outstanding_q;
        discard_d      = discard_q;
        holdReq_d      = holdReq_q;
        holdAddr_d     = holdAddr_q;
        faultPending_d = faultPending_q;
        stalled_d      = stalled_q;
        for (int i = 0; i < 2; i++) begin
            bufInstr_d[i]   = bufInstr_q[i];
            bufPc_d[i]      = bufPc_q[i];
            bufFault_d[i]   = bufFault_q[i];
            inflightPc_d[i] = inflightPc_q[i];
        end

        // In-flight PCs: grants append at the tail, responses retire the oldest.
        case ({grant, respValid})
            2'b10: begin
                inflightPc_d[outstanding_q[0]] = mem_addr_o;
                outstanding_d = outstanding_q + 2'd1;
            end
            2'b01: begin
                inflightPc_d[0] = inflightPc_q[1];
                outstanding_d   = outstanding_q - 2'd1;
            end
            2'b11: begin
                if (outstanding_q == 2'd1) begin
                    inflightPc_d[0] = mem_addr_o;
                end else begin
                    inflightPc_d[0] = inflightPc_q[1];
                    inflightPc_d[1] = mem_addr_o;
                end
            end
            default: ;
        endcase

        if (redirect_i) begin
            fetchPc_d      = redirectTarget;
            count_d        = 2'd0;
            discard_d      = outstanding_d;
            holdReq_d      = mem_req_o && !mem_gnt_i;
            holdAddr_d     = mem_addr_o;
            faultPending_d = redirectMisaligned;
            stalled_d      = redirectMisaligned;
        end else begin
            if (normalGrant) fetchPc_d = fetchPc_q + 32'd4;
            if (holdGrant) holdReq_d = 1'b0;
            if (faultPush) faultPending_d = 1'b0;
            discard_d = discard_q + {1'b0, holdGrant} - {1'b0, respDrop};

            if (pushEn && popEn) begin
                if (count_q == 2'd1) begin
                    bufInstr_d[0] = pushInstr;
                    bufPc_d[0]    = pushPc;
                    bufFault_d[0] = pushFault;
                end else begin
                    bufInstr_d[0] = bufInstr_q[1];
                    bufPc_d[0]    = bufPc_q[1];
                    bufFault_d[0] = bufFault_q[1];
                    bufInstr_d[1] = pushInstr;
                    bufPc_d[1]    = pushPc;
                    bufFault_d[1] = pushFault;
                end
            end else if (popEn) begin
                bufInstr_d[0] = bufInstr_q[1];
                bufPc_d[0]    = bufPc_q[1];
                bufFault_d[0] = bufFault_q[1];
                count_d       = count_q - 2'd1;
            end else if (pushEn) begin
                bufInstr_d[count_q[0]] = pushInstr;
                bufPc_d[count_q[0]]    = pushPc;
                bufFault_d[count_q[0]] = pushFault;
                count_d                = count_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetchPc_q      <= RESET_PC;
            count_q        <= 2'd0;
            outstanding_q  <= 2'd0;
            discard_q      <= 2'd0;
            holdReq_q      <= 1'b0;
            holdAddr_q     <= 32'd0;
            faultPending_q <= 1'b0;
            stalled_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                bufInstr_q[i]   <= 32'd0;
                bufPc_q[i]      <= 32'd0;
                bufFault_q[i]   <= 1'b0;
                inflightPc_q[i] <= 32'd0;
            end
        end else begin
            fetchPc_q      <= fetchPc_d;
            count_q        <= count_d;
            outstanding_q  <= outstanding_d;
            discard_q      <= discard_d;
            holdReq_q      <= holdReq_d;
            holdAddr_q     <= holdAddr_d;
            faultPending_q <= faultPending_d;
            stalled_q      <= stalled_d;
            for (int i = 0; i < 2; i++) begin
                bufInstr_q[i]   <= bufInstr_d[i];
                bufPc_q[i]      <= bufPc_d[i];
                bufFault_q[i]   <= bufFault_d[i];
                inflightPc_q[i] <= inflightPc_d[i];
            end
        end
    end

    // A push into a full buffer means the credit check was bypassed.
    assert property (@(posedge clk_i) disable iff (reset_i) !(pushEn && !popEn && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-configurable memory responder plus an
// expected-instruction scoreboard checked whenever the consumer pops the buffer head.
module tb_fetch_unit;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        instr_fault_o;

    int     checks = 0;
    int     errors = 0;
    int     popCount = 0;
    int     grantCount = 0;
    int     memCycle = 0;
    int     memLatency = 1;
    logic   gntEnable = 1'b1;
    entry_t expQ[$];
    resp_t  respQ[$];

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .instr_fault_o (instr_fault_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'd0) return 32'h0000_0537;
        return (addr * 32'h0001_0003) ^ 32'h00A0_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic redirect, input logic [31:0] pc, input logic ready);
        redirect_i    = redirect;
        redirect_pc_i = pc;
        instr_ready_i = ready;
        if (redirect) expQ.delete();
    endtask

    task automatic expectFetch(input logic [31:0] pc);
        entry_t e;
        e.instr = memWord(pc);
        e.pc    = pc;
        e.fault = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic waitPops(input int count, input int budget);
        int target;
        int n;
        target = popCount + count;
        n = 0;
        while (popCount < target && n < budget) begin
            nextCycle();
            n++;
        end
        checks++;
        assert (popCount >= target) else begin
            errors++;
            $error("[TB] FAIL popTimeout: observed %0d pops expected %0d", popCount, target);
        end
    endtask

    task automatic waitReq(input int budget);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!mem_req_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        assert (mem_req_o === 1'b1) else begin
            errors++;
            $error("[TB] FAIL reqTimeout: observed %b expected 1", mem_req_o);
        end
    endtask

    // Memory responder: grants per gntEnable, returns responses in order after memLatency cycles.
    initial begin : memoryModel
        resp_t r;
        logic        holdValid;
        logic [31:0] holdAddr;
        holdValid    = 1'b0;
        holdAddr     = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        forever begin
            @(negedge clk_i);
            memCycle++;
            if (reset_i) begin
                respQ.delete();
                grantCount   = 0;
                holdValid    = 1'b0;
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'd0;
                mem_gnt_i    = gntEnable;
            end else begin
                if (respQ.size() != 0 && respQ[0].due <= memCycle) begin
                    r = respQ.pop_front();
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = memWord(r.addr);
                end else begin
                    mem_rvalid_i = 1'b0;
                    mem_rdata_i  = 32'd0;
                end
                mem_gnt_i = gntEnable;
                if (holdValid && mem_req_o) checkOutput("addrStable", mem_addr_o, holdAddr);
                holdValid = mem_req_o && !mem_gnt_i;
                holdAddr  = mem_addr_o;
                if (mem_req_o && mem_gnt_i) begin
                    r.addr = mem_addr_o;
                    r.due  = memCycle + memLatency;
                    respQ.push_back(r);
                    grantCount++;
                end
            end
        end
    end

    // Scoreboard: every accepted head entry is compared against the oldest expectation.
    initial begin : scoreboardChecker
        entry_t e;
        forever begin
            @(negedge clk_i);
            if (!reset_i && instr_valid_o && instr_ready_i && !redirect_i) begin
                checks++;
                assert (expQ.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpectedPop: observed pc %h expected no entry", instr_pc_o);
                end
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("popInstr", instr_o, e.instr);
                    checkOutput("popPc", instr_pc_o, e.pc);
                    checkOutput("popFault", 32'(instr_fault_o), 32'(e.fault));
                end
                popCount++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: observed no completion expected finish before 100000");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        reset_i = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0);
        repeat (3) @(posedge clk_i);

        // Reset state, with the memory granting (ignored) throughout
        @(negedge clk_i);
        checkOutput("resetReq", 32'(mem_req_o), 32'd0);
        checkOutput("resetValid", 32'(instr_valid_o), 32'd0);
        checkOutput("resetFault", 32'(instr_fault_o), 32'd0);
        checkOutput("resetInstr", instr_o, 32'd0);
        checkOutput("resetPc", instr_pc_o, 32'd0);

        // First fetch right after reset, fastest response path
        nextCycle();
        reset_i = 1'b0;
        @(negedge clk_i);
        checkOutput("firstReq", 32'(mem_req_o), 32'd1);
        checkOutput("firstAddr", mem_addr_o, TB_RESET_PC);
        @(negedge clk_i);
        checkOutput("secondAddr", mem_addr_o, TB_RESET_PC + 32'd4);
        @(negedge clk_i);
        checkOutput("fastValid", 32'(instr_valid_o), 32'd1);
        checkOutput("fastInstr", instr_o, 32'h0000_0537);
        checkOutput("fastPc", instr_pc_o, TB_RESET_PC);

        // Consumer stalled: credit stops fetching at two
        repeat (6) @(negedge clk_i);
        checkOutput("creditGrants", 32'(grantCount), 32'd2);
        checkOutput("creditReq", 32'(mem_req_o), 32'd0);
        checkOutput("creditValid", 32'(instr_valid_o), 32'd1);

        // Streaming consumption with back-to-back push/pop
        nextCycle();
        for (int i = 0; i < 5; i++) expectFetch(TB_RESET_PC + 32'(4 * i));
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitPops(5, 60);
        applyStimulus(1'b0, 32'd0, 1'b0);

        // Redirect with two responses in flight: both must be dropped
        repeat (4) nextCycle();
        memLatency = 4;
        applyStimulus(1'b1, 32'h0000_0200, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        for (int n = 0; n < 20 && respQ.size() < 2; n++) nextCycle();
        checkOutput("twoInFlight", 32'(respQ.size()), 32'd2);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0);
        nextCycle();
        expectFetch(32'h0000_0100);
        expectFetch(32'h0000_0104);
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitPops(2, 60);
        applyStimulus(1'b0, 32'd0, 1'b0);

        // Redirect while a request waits for grant: old address held, its data dropped
        repeat (10) nextCycle();
        gntEnable = 1'b0;
        applyStimulus(1'b1, 32'h0000_0300, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        memLatency = 1;
        @(negedge clk_i);
        checkOutput("heldReqBefore", 32'(mem_req_o), 32'd1);
        checkOutput("heldAddrBefore", mem_addr_o, 32'h0000_0300);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0180, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("heldReq", 32'(mem_req_o), 32'd1);
            checkOutput("heldAddr", mem_addr_o, 32'h0000_0300);
        end
        nextCycle();
        gntEnable = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("discardNoReq", 32'(mem_req_o), 32'd0);
        waitReq(10);
        checkOutput("targetAddr", mem_addr_o, 32'h0000_0180);
        nextCycle();
        expectFetch(32'h0000_0180);
        expectFetch(32'h0000_0184);
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitPops(2, 60);
        applyStimulus(1'b0, 32'd0, 1'b0);

        // Fetch PC wraps past 2^32; then redirect wins over a simultaneous pop
        repeat (6) nextCycle();
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0);
        nextCycle();
        for (int i = 0; i < 6; i++) expectFetch(32'hFFFF_FFF8 + 32'(4 * i));
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitPops(3, 60);
        applyStimulus(1'b1, 32'h0000_0102, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);

`ifdef FETCH_MISALIGN_CHECK_EN
        begin
            entry_t f;
            f.instr = 32'h0000_0013;
            f.pc    = 32'h0000_0102;
            f.fault = 1'b1;
            expQ.push_back(f);
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitPops(1, 40);
        applyStimulus(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("stallNoReq", 32'(mem_req_o), 32'd0);
        end
        nextCycle();
`else
        waitReq(20);
        checkOutput("alignedAddr", mem_addr_o, 32'h0000_0100);
        nextCycle();
        expectFetch(32'h0000_0100);
        expectFetch(32'h0000_0104);
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitPops(2, 60);
        applyStimulus(1'b0, 32'd0, 1'b0);
`endif

        repeat (2) nextCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
